// File: rtl/vad_pkg.sv
// vad_pkg: shared types and constants for the VAD decision output block.
//   - result code constants produced by the final compare stage
//   - vad_state_t: smoothing FSM state encoding (also exported as debug)
//   - vad_rec_t: default decision record {frame, decision} for an 8-bit index
package vad_pkg;

    localparam logic [1:0] RES_NONE = 2'b00;
    localparam logic [1:0] RES_CLS2 = 2'b01;  // non-speech
    localparam logic [1:0] RES_CLS1 = 2'b10;  // speech
    localparam logic [1:0] RES_ILL  = 2'b11;

    typedef enum logic [1:0] {
        SILENCE = 2'd0,
        ONSET   = 2'd1,
        SPEECH  = 2'd2,
        HANG    = 2'd3
    } vad_state_t;

    localparam int FRAME_W_DEF = 8;

    typedef struct packed {
        logic [FRAME_W_DEF-1:0] frame;
        logic                   decision;
    } vad_rec_t;

    // Decision is asserted while speech is active or being held over.
    function automatic logic vad_decision(input vad_state_t st);
        return (st == SPEECH) || (st == HANG);
    endfunction

endpackage

// File: rtl/vad_decision_out_if.sv
// vad_decision_out_if: valid/ready record channel from the VAD block to the host.
//   out_valid    : record available (master -> slave)
//   out_ready    : downstream can accept (slave -> master)
//   out_decision : smoothed VAD decision
//   out_frame    : frame index the record belongs to
interface vad_decision_out_if #(
    parameter int FRAME_W = 8
);
    logic               out_valid;
    logic               out_ready;
    logic               out_decision;
    logic [FRAME_W-1:0] out_frame;

    modport master (
        output out_valid,
        output out_decision,
        output out_frame,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_decision,
        input  out_frame,
        output out_ready
    );
endinterface

// File: rtl/vad_out_buf.sv
// vad_out_buf: one-entry valid/ready output register.
//   clk, rst_n : clock, async active-low reset
//   clr_i      : sync clear, discards any held record and the overflow flag
//   push_i     : a new record is offered this cycle (rec_i)
//   ready_i    : downstream ready
//   valid_o    : record held
//   rec_o      : held record, stable while valid_o && !ready_i
//   overflow_o : sticky, set when a push arrives while the entry is blocked
module vad_out_buf
    import vad_pkg::*;
#(
    parameter type rec_t = vad_rec_t
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic push_i,
    input  rec_t rec_i,
    input  logic ready_i,
    output logic valid_o,
    output rec_t rec_o,
    output logic overflow_o
);

    logic valid_q, valid_d;
    rec_t rec_q,   rec_d;
    logic ovf_q,   ovf_d;
    logic load, drop;

    // A completing handshake frees the entry in the same edge, so a push
    // can replace the outgoing record without a bubble.
    assign load = push_i && (!valid_q || ready_i);
    assign drop = push_i && valid_q && !ready_i;

    always_comb begin
        valid_d = valid_q;
        rec_d   = rec_q;
        ovf_d   = ovf_q | drop;
        if (load) begin
            valid_d = 1'b1;
            rec_d   = rec_i;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            rec_q   <= '0;
            ovf_q   <= 1'b0;
        end else if (clr_i) begin
            valid_q <= 1'b0;
            rec_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            rec_q   <= rec_d;
            ovf_q   <= ovf_d;
        end
    end

    assign valid_o    = valid_q;
    assign rec_o      = rec_q;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/vad_decision_out.sv
// vad_decision_out: onset/hangover smoothing of the per-frame class code and
// record output toward the host.
//   clk, rst_n : clock, async active-low reset
//   cls_en     : compare-stage enable; result_in is valid one cycle later
//   result_in  : 10 speech, 01 non-speech, 00 no result, 11 illegal
//   clr        : sync soft clear, highest priority
//   out_if     : record channel (valid/ready, decision, frame index)
//   vad_state  : current FSM state (debug)
//   overflow   : sticky, a record was dropped under backpressure
//   code_err   : sticky, an illegal code was sampled
module vad_decision_out
    import vad_pkg::*;
#(
    parameter int ONSET_FRAMES = 2,
    parameter int HANG_FRAMES  = 3,
    parameter int CNT_W        = 4,
    parameter int FRAME_W      = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cls_en,
    input  logic [1:0]          result_in,
    input  logic                clr,
    vad_decision_out_if.master  out_if,
    output logic [1:0]          vad_state,
    output logic                overflow,
    output logic                code_err
);

    typedef struct packed {
        logic [FRAME_W-1:0] frame;
        logic               decision;
    } rec_t;

    localparam logic [CNT_W-1:0]   CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   ONSET_C   = CNT_W'(ONSET_FRAMES);
    localparam logic [CNT_W-1:0]   HANG_C    = CNT_W'(HANG_FRAMES);
    localparam logic [FRAME_W-1:0] FRAME_ONE = {{(FRAME_W-1){1'b0}}, 1'b1};

    logic               en_q;
    vad_state_t         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [FRAME_W-1:0] frame_q;
    logic               cerr_q;

    logic valid_frame, is_speech;
    rec_t rec_new, rec_out;

    // en_q marks the cycle in which result_in belongs to the enabled frame.
    assign valid_frame = en_q && (result_in == RES_CLS1 || result_in == RES_CLS2);
    assign is_speech   = (result_in == RES_CLS1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q    <= 1'b0;
            state_q <= SILENCE;
            cnt_q   <= '0;
            frame_q <= '0;
            cerr_q  <= 1'b0;
        end else if (clr) begin
            en_q    <= 1'b0;
            state_q <= SILENCE;
            cnt_q   <= '0;
            frame_q <= '0;
            cerr_q  <= 1'b0;
        end else begin
            en_q    <= cls_en;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (valid_frame)
                frame_q <= frame_q + FRAME_ONE;
            if (en_q && result_in == RES_ILL)
                cerr_q <= 1'b1;
        end
    end

    // Smoothing FSM; only valid frames move it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (valid_frame) begin
            case (state_q)
                SILENCE: begin
                    if (is_speech) begin
                        if (ONSET_FRAMES == 1) begin
                            state_d = SPEECH;
                        end else begin
                            state_d = ONSET;
                            cnt_d   = CNT_ONE;
                        end
                    end
                end
                ONSET: begin
                    if (is_speech) begin
                        if (cnt_q + CNT_ONE == ONSET_C) begin
                            state_d = SPEECH;
                            cnt_d   = '0;
                        end else begin
                            cnt_d   = cnt_q + CNT_ONE;
                        end
                    end else begin
                        state_d = SILENCE;
                        cnt_d   = '0;
                    end
                end
                SPEECH: begin
                    if (!is_speech) begin
                        if (HANG_FRAMES == 0) begin
                            state_d = SILENCE;
                        end else begin
                            state_d = HANG;
                            cnt_d   = CNT_ONE;
                        end
                    end
                end
                HANG: begin
                    if (is_speech) begin
                        state_d = SPEECH;
                        cnt_d   = '0;
                    end else if (cnt_q == HANG_C) begin
                        state_d = SILENCE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = SILENCE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // The record reflects the state after this frame is processed and the
    // frame index before it is bumped.
    always_comb begin
        rec_new          = '0;
        rec_new.frame    = frame_q;
        rec_new.decision = vad_decision(state_d);
    end

    vad_out_buf #(
        .rec_t (rec_t)
    ) u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (clr),
        .push_i     (valid_frame),
        .rec_i      (rec_new),
        .ready_i    (out_if.out_ready),
        .valid_o    (out_if.out_valid),
        .rec_o      (rec_out),
        .overflow_o (overflow)
    );

    assign out_if.out_decision = rec_out.decision;
    assign out_if.out_frame    = rec_out.frame;
    assign vad_state           = state_q;
    assign code_err            = cerr_q;

endmodule

// File: tb/tb_vad_decision_out.sv
module tb_vad_decision_out;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cls_en;
    logic [1:0] result_in;
    logic       clr;
    logic [1:0] vad_state;
    logic       overflow;
    logic       code_err;

    int checks = 0;
    int errors = 0;

    vad_decision_out_if #(.FRAME_W(8)) oif ();

    vad_decision_out #(
        .ONSET_FRAMES (2),
        .HANG_FRAMES  (3),
        .CNT_W        (4),
        .FRAME_W      (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cls_en    (cls_en),
        .result_in (result_in),
        .clr       (clr),
        .out_if    (oif),
        .vad_state (vad_state),
        .overflow  (overflow),
        .code_err  (code_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // cls_en in one cycle, code in the next; returns one cycle after the
    // frame event edge, where a loaded record is visible.
    task automatic send_frame(input logic [1:0] code);
        cls_en = 1'b1;
        tick();
        cls_en    = 1'b0;
        result_in = code;
        tick();
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++; if (oif.out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", oif.out_valid); end
        checks++; if (oif.out_decision !== 1'b0) begin errors++; $display("FAIL rst_decision: got %b want 0", oif.out_decision); end
        checks++; if (oif.out_frame !== 8'd0) begin errors++; $display("FAIL rst_frame: got %0d want 0", oif.out_frame); end
        checks++; if (vad_state !== 2'd0) begin errors++; $display("FAIL rst_state: got %0d want 0", vad_state); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow: got %b want 0", overflow); end
        checks++; if (code_err !== 1'b0) begin errors++; $display("FAIL rst_code_err: got %b want 0", code_err); end
        rst_n = 1'b1;
        tick();
        // latency: cls_en in cycle N -> out_valid in cycle N+2
        cls_en = 1'b1;
        tick();
        cls_en    = 1'b0;
        result_in = 2'b01;
        checks++; if (oif.out_valid !== 1'b0) begin errors++; $display("FAIL lat_early_valid: got %b want 0", oif.out_valid); end
        tick();
        checks++; if (oif.out_valid !== 1'b1) begin errors++; $display("FAIL lat_valid: got %b want 1", oif.out_valid); end
        checks++; if (oif.out_decision !== 1'b0) begin errors++; $display("FAIL lat_decision: got %b want 0", oif.out_decision); end
        checks++; if (oif.out_frame !== 8'd0) begin errors++; $display("FAIL lat_frame: got %0d want 0", oif.out_frame); end
        checks++; if (vad_state !== 2'd0) begin errors++; $display("FAIL lat_state: got %0d want 0", vad_state); end
    endtask

    task automatic test_onset_hang();
        logic [1:0] codes [6] = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01};
        logic       dec   [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [1:0] st    [6] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd0};
        do_clr();
        oif.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send_frame(codes[i]);
            checks++; if (oif.out_valid !== 1'b1) begin errors++; $display("FAIL oh_valid[%0d]: got %b want 1", i, oif.out_valid); end
            checks++; if (oif.out_decision !== dec[i]) begin errors++; $display("FAIL oh_decision[%0d]: got %b want %b", i, oif.out_decision, dec[i]); end
            checks++; if (oif.out_frame !== 8'(i)) begin errors++; $display("FAIL oh_frame[%0d]: got %0d want %0d", i, oif.out_frame, i); end
            checks++; if (vad_state !== st[i]) begin errors++; $display("FAIL oh_state[%0d]: got %0d want %0d", i, vad_state, st[i]); end
        end
    endtask

    task automatic test_onset_abort();
        logic [1:0] codes [4] = '{2'b10, 2'b01, 2'b10, 2'b01};
        do_clr();
        oif.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send_frame(codes[i]);
            checks++; if (oif.out_decision !== 1'b0) begin errors++; $display("FAIL abort_decision[%0d]: got %b want 0", i, oif.out_decision); end
        end
        checks++; if (vad_state !== 2'd0) begin errors++; $display("FAIL abort_state: got %0d want 0", vad_state); end
    endtask

    task automatic test_backpressure();
        do_clr();
        oif.out_ready = 1'b0;
        cls_en = 1'b1;
        tick();
        result_in = 2'b10;
        tick();
        cls_en = 1'b0;
        tick();
        checks++; if (oif.out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b want 1", oif.out_valid); end
        checks++; if (oif.out_frame !== 8'd0) begin errors++; $display("FAIL bp_frame: got %0d want 0", oif.out_frame); end
        checks++; if (oif.out_decision !== 1'b0) begin errors++; $display("FAIL bp_decision: got %b want 0", oif.out_decision); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL bp_overflow: got %b want 1", overflow); end
        checks++; if (vad_state !== 2'd2) begin errors++; $display("FAIL bp_state: got %0d want 2", vad_state); end
        tick();
        checks++; if (oif.out_frame !== 8'd0 || oif.out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold: got valid %b frame %0d want 1/0", oif.out_valid, oif.out_frame); end
        oif.out_ready = 1'b1;
        send_frame(2'b01);
        checks++; if (oif.out_frame !== 8'd2) begin errors++; $display("FAIL bp_next_frame: got %0d want 2", oif.out_frame); end
        checks++; if (oif.out_decision !== 1'b1) begin errors++; $display("FAIL bp_next_decision: got %b want 1", oif.out_decision); end
        checks++; if (vad_state !== 2'd3) begin errors++; $display("FAIL bp_next_state: got %0d want 3", vad_state); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL bp_sticky: got %b want 1", overflow); end
    endtask

    task automatic test_codes();
        do_clr();
        oif.out_ready = 1'b1;
        send_frame(2'b10);
        checks++; if (oif.out_frame !== 8'd0 || vad_state !== 2'd1) begin errors++; $display("FAIL code_s0: got frame %0d state %0d want 0/1", oif.out_frame, vad_state); end
        send_frame(2'b00);
        checks++; if (oif.out_valid !== 1'b0) begin errors++; $display("FAIL code_00_valid: got %b want 0", oif.out_valid); end
        checks++; if (code_err !== 1'b0) begin errors++; $display("FAIL code_00_err: got %b want 0", code_err); end
        checks++; if (vad_state !== 2'd1) begin errors++; $display("FAIL code_00_state: got %0d want 1", vad_state); end
        send_frame(2'b11);
        checks++; if (oif.out_valid !== 1'b0) begin errors++; $display("FAIL code_11_valid: got %b want 0", oif.out_valid); end
        checks++; if (code_err !== 1'b1) begin errors++; $display("FAIL code_11_err: got %b want 1", code_err); end
        checks++; if (vad_state !== 2'd1) begin errors++; $display("FAIL code_11_state: got %0d want 1", vad_state); end
        send_frame(2'b10);
        checks++; if (oif.out_valid !== 1'b1 || oif.out_frame !== 8'd1) begin errors++; $display("FAIL code_s1: got valid %b frame %0d want 1/1", oif.out_valid, oif.out_frame); end
        checks++; if (vad_state !== 2'd2 || oif.out_decision !== 1'b1) begin errors++; $display("FAIL code_s1_state: got state %0d dec %b want 2/1", vad_state, oif.out_decision); end
        send_frame(2'b11);
        checks++; if (oif.out_valid !== 1'b0) begin errors++; $display("FAIL code_11b_valid: got %b want 0", oif.out_valid); end
        send_frame(2'b10);
        checks++; if (oif.out_frame !== 8'd2 || vad_state !== 2'd2) begin errors++; $display("FAIL code_s2: got frame %0d state %0d want 2/2", oif.out_frame, vad_state); end
        checks++; if (code_err !== 1'b1) begin errors++; $display("FAIL code_err_sticky: got %b want 1", code_err); end
    endtask

    task automatic test_reset_mid_hang();
        do_clr();
        oif.out_ready = 1'b1;
        send_frame(2'b10);
        send_frame(2'b10);
        send_frame(2'b01);
        oif.out_ready = 1'b0;
        send_frame(2'b01);
        send_frame(2'b11);
        checks++; if (oif.out_valid !== 1'b1 || vad_state !== 2'd3) begin errors++; $display("FAIL mh_pre: got valid %b state %0d want 1/3", oif.out_valid, vad_state); end
        checks++; if (overflow !== 1'b1 || code_err !== 1'b1) begin errors++; $display("FAIL mh_pre_flags: got ovf %b err %b want 1/1", overflow, code_err); end
        #3 rst_n = 1'b0;
        #1;
        checks++; if (oif.out_valid !== 1'b0) begin errors++; $display("FAIL mh_valid: got %b want 0", oif.out_valid); end
        checks++; if (oif.out_frame !== 8'd0 || oif.out_decision !== 1'b0) begin errors++; $display("FAIL mh_rec: got frame %0d dec %b want 0/0", oif.out_frame, oif.out_decision); end
        checks++; if (vad_state !== 2'd0) begin errors++; $display("FAIL mh_state: got %0d want 0", vad_state); end
        checks++; if (overflow !== 1'b0 || code_err !== 1'b0) begin errors++; $display("FAIL mh_flags: got ovf %b err %b want 0/0", overflow, code_err); end
        tick();
        rst_n = 1'b1;
        oif.out_ready = 1'b1;
        send_frame(2'b10);
        checks++; if (oif.out_frame !== 8'd0 || vad_state !== 2'd1) begin errors++; $display("FAIL mh_after: got frame %0d state %0d want 0/1", oif.out_frame, vad_state); end
        send_frame(2'b10);
        checks++; if (vad_state !== 2'd2 || oif.out_frame !== 8'd1) begin errors++; $display("FAIL mh_after2: got state %0d frame %0d want 2/1", vad_state, oif.out_frame); end
    endtask

    task automatic test_wrap();
        logic [7:0] expf;
        do_clr();
        oif.out_ready = 1'b1;
        for (int i = 0; i < 257; i++) begin
            send_frame(2'b01);
            expf = i[7:0];
            checks++; if (oif.out_valid !== 1'b1 || oif.out_frame !== expf) begin errors++; $display("FAIL wrap_frame[%0d]: got valid %b frame %0d want 1/%0d", i, oif.out_valid, oif.out_frame, expf); end
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        cls_en        = 1'b0;
        clr           = 1'b0;
        result_in     = 2'b00;
        oif.out_ready = 1'b1;
        #2;
        test_reset();
        test_onset_hang();
        test_onset_abort();
        test_backpressure();
        test_codes();
        test_reset_mid_hang();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
